stall_data_mem: RTL and testbench

//  Multi-cycle data-memory responder on the far side of the proc load/store port.

---
 rtl/stall_data_mem.sv | 137 +++++++++++++
 tb/tb_stall_data_mem.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_data_mem.sv
// ----------------------------------------------------------------------------
// stall_data_mem
//   Multi-cycle data-memory responder for the processor load/store port.
//   It accepts one read or write at a time and raises Stall while it is busy.
//   It pulses Done, with the read data, LATENCY cycles after accepting a request.
//
// Parameters
//   MEM_AW   word-address width; the array holds 2**MEM_AW x 16-bit words (<= 14)
//   LATENCY  number of cycles from request acceptance to the Done pulse (1..15)
//
// Ports
//   clk      rising-edge system clock
//   rst      synchronous reset, active-high
//   Rd, Wr   request strobes; the initiator holds them until Done
//   Addr     byte address; the word index is Addr[MEM_AW:1]
//   DataIn   write data
//   DataOut  read data; valid only while Done=1, otherwise 0
//   Stall    busy indication (combinational)
//   Done     one-cycle completion pulse
//   err      one-cycle protocol-error pulse
//
// Configuration
//   STALL_MEM_ALIGN_CHECK_EN  when defined, a request with Addr[0]=1 is rejected
//                             with err. When it is not defined, Addr[0] is ignored.
// ----------------------------------------------------------------------------
module stall_data_mem #(
    parameter int MEM_AW  = 8,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          count;
    logic                op_wr;
    logic [MEM_AW-1:0]   idx_q;
    logic [15:0]         data_q;
    logic [15:0]         mem [0:(1<<MEM_AW)-1];

    logic [MEM_AW-1:0]   req_idx;
    logic                req_valid;
    logic                req_err;
    logic                unused_addr;

    // Upper address bits are dropped, so addresses wrap modulo the array size.
    assign req_idx     = Addr[MEM_AW:1];
    assign unused_addr = ^{Addr[15:MEM_AW+1], Addr[0]};

`ifdef STALL_MEM_ALIGN_CHECK_EN
    assign req_valid = (Rd ^ Wr) & ~Addr[0];
    assign req_err   = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
`else
    assign req_valid = Rd ^ Wr;
    assign req_err   = Rd & Wr;
`endif

    // Stall is raised in the accepting cycle itself, so the initiator
    // freezes without waiting a cycle. Stall is low in the DONE cycle.
    assign Stall = (state == BUSY) | ((state == IDLE) & req_valid);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values that were present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            op_wr   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            DataOut <= '0;
            Done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            Done    <= 1'b0;
            err     <= 1'b0;
            DataOut <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_wr  <= Wr;
                        idx_q  <= req_idx;
                        data_q <= DataIn;
                        count  <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            DataOut <= Wr ? 16'h0000 : mem[req_idx];
                        end else begin
                            state <= BUSY;
                        end
                    end else if (req_err) begin
                        err <= 1'b1;
                    end
                end
                BUSY: begin
                    // Only the latched copies of the request are used here.
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        DataOut <= op_wr ? 16'h0000 : mem[idx_q];
                    end
                end
                DONE: begin
                    // The initiator still shows the finished request, so it is ignored.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset. Clearing it would cost a full
    // write sweep, and its contents are allowed to survive rst.
    // A write commits at the end of its DONE cycle unless reset aborts it.
    always_ff @(posedge clk) begin
        if (!rst && (state == DONE) && op_wr) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_stall_data_mem.sv
module tb_stall_data_mem;

    localparam int N  = 2;   // instance 0: LATENCY=4, instance 1: LATENCY=1
    localparam int AW = 8;
`ifdef STALL_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_s   [N];
    logic        wr_s   [N];
    logic [15:0] addr_s [N];
    logic [15:0] din_s  [N];
    logic [15:0] dout_s [N];
    logic        stall_s[N];
    logic        done_s [N];
    logic        err_s  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        stall_data_mem #(
            .MEM_AW (AW),
            .LATENCY((g == 0) ? 4 : 1)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .Rd     (rd_s[g]),
            .Wr     (wr_s[g]),
            .Addr   (addr_s[g]),
            .DataIn (din_s[g]),
            .DataOut(dout_s[g]),
            .Stall  (stall_s[g]),
            .Done   (done_s[g]),
            .err    (err_s[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural reference model ----------------
    // Each transaction is tracked by its acceptance cycle. Stall is expected
    // until that cycle plus the latency, and Done is expected at exactly that
    // cycle plus the latency. Written words are kept in a plain array.
    logic [15:0] m_mem   [N][256];
    bit          m_known [N][256];
    bit          m_busy  [N];
    int          m_t     [N];
    bit          m_wr    [N];
    int          m_idx   [N];
    logic [15:0] m_data  [N];
    bit          m_err_nx[N];

    always @(negedge clk) begin : cmp
        bit          valid, perr, e_stall, e_done, dchk;
        logic [15:0] e_dout;
        for (int k = 0; k < N; k++) begin
            valid = (rd_s[k] ^ wr_s[k]) && !(ALIGN && addr_s[k][0]);
            perr  = (rd_s[k] && wr_s[k]) || (ALIGN && (rd_s[k] || wr_s[k]) && addr_s[k][0]);
            e_done = 1'b0; dchk = 1'b0; e_dout = 16'h0; e_stall = 1'b0;
            if (m_busy[k]) begin
                if (cyc == m_t[k] + lat_of(k)) begin
                    e_done = 1'b1;
                    if (m_wr[k]) begin
                        dchk = 1'b1;
                    end else begin
                        e_dout = m_mem[k][m_idx[k]];
                        dchk   = m_known[k][m_idx[k]];
                    end
                end else begin
                    e_stall = 1'b1;
                end
            end else begin
                e_stall = valid;
            end
            if (chk_en) begin
                check($sformatf("stall[%0d]@%0d", k, cyc), {31'b0, stall_s[k]}, {31'b0, e_stall});
                check($sformatf("done[%0d]@%0d", k, cyc), {31'b0, done_s[k]}, {31'b0, e_done});
                check($sformatf("err[%0d]@%0d", k, cyc), {31'b0, err_s[k]}, {31'b0, m_err_nx[k]});
                if (dchk)
                    check($sformatf("dout[%0d]@%0d", k, cyc), {16'b0, dout_s[k]}, {16'b0, e_dout});
            end
            // advance the model to the next cycle
            if (rst) begin
                m_busy[k]   = 1'b0;
                m_err_nx[k] = 1'b0;
            end else if (m_busy[k]) begin
                m_err_nx[k] = 1'b0;
                if (e_done) begin
                    if (m_wr[k]) begin
                        m_mem[k][m_idx[k]]   = m_data[k];
                        m_known[k][m_idx[k]] = 1'b1;
                    end
                    m_busy[k] = 1'b0;
                end
            end else begin
                m_err_nx[k] = perr;
                if (valid) begin
                    m_busy[k] = 1'b1;
                    m_t[k]    = cyc;
                    m_wr[k]   = wr_s[k];
                    m_idx[k]  = int'(addr_s[k][AW:1]);
                    m_data[k] = din_s[k];
                end
            end
        end
    end

    // ---------------- initiator ----------------
    task automatic req(input int k, input bit r, input bit w, input logic [15:0] a,
                       input logic [15:0] d, output bit got_done, output int lat_seen,
                       output logic [15:0] data);
        int t0;
        bit is_err;
        is_err   = (r && w) || (ALIGN && (r || w) && a[0]);
        got_done = 1'b0;
        lat_seen = -1;
        data     = 16'h0;
        @(posedge clk); #1;
        rd_s[k] = r; wr_s[k] = w; addr_s[k] = a; din_s[k] = d;
        t0 = cyc;
        if (is_err) begin
            // A rejected request is presented for one cycle only.
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done_s[k]) begin
                    got_done = 1'b1;
                    lat_seen = cyc - t0;
                    data     = dout_s[k];
                    break;
                end
            end
            if (!got_done) check("req_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        rd_s[k] = 1'b0; wr_s[k] = 1'b0;
    endtask

    task automatic count_pulses(input int k, input int n, output int n_done, output int n_err);
        n_done = 0; n_err = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done_s[k]) n_done++;
            if (err_s[k])  n_err++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          gd;
        int          lat, nd, ne;
        logic [15:0] dat, a;
        int          k, op;

        for (int i = 0; i < N; i++) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 16'h0; din_s[i] = 16'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // 1. idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) begin
                check("idle_stall", {31'b0, stall_s[j]}, 32'd0);
                check("idle_done",  {31'b0, done_s[j]},  32'd0);
                check("idle_err",   {31'b0, err_s[j]},   32'd0);
                check("idle_dout",  {16'b0, dout_s[j]},  32'd0);
            end
        end

        // 2. write then read, latency 4
        req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, gd, lat, dat);
        check("wr_done", {31'b0, gd}, 32'd1);
        check("wr_lat", lat, 32'd4);
        req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, gd, lat, dat);
        check("rd_lat", lat, 32'd4);
        check("rd_data", {16'b0, dat}, 32'h0000BEEF);

        // 3. Rd&Wr collision: one err pulse, memory untouched
        req(0, 1'b0, 1'b1, 16'h0004, 16'h1111, gd, lat, dat);
        req(0, 1'b1, 1'b1, 16'h0004, 16'h2222, gd, lat, dat);
        count_pulses(0, 4, nd, ne);
        check("coll_err_cnt", ne, 32'd1);
        check("coll_done_cnt", nd, 32'd0);
        check("coll_stall_after", {31'b0, stall_s[0]}, 32'd0);
        req(0, 1'b1, 1'b0, 16'h0004, 16'h0000, gd, lat, dat);
        check("coll_mem_kept", {16'b0, dat}, 32'h00001111);

        // 4. reset in the middle of a write
        req(0, 1'b0, 1'b1, 16'h0020, 16'h5555, gd, lat, dat);
        @(posedge clk); #1;
        wr_s[0] = 1'b1; addr_s[0] = 16'h0020; din_s[0] = 16'h1234;   // cycle T
        @(posedge clk); #1;                                          // T+1
        @(posedge clk); #1;                                          // T+2
        rst = 1'b1; wr_s[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        count_pulses(0, 8, nd, ne);
        check("rst_no_done", nd, 32'd0);
        req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, gd, lat, dat);
        check("rst_no_commit", {16'b0, dat}, 32'h00005555);

        // 5. wrap-around at latency 1
        req(1, 1'b0, 1'b1, 16'h0202, 16'hA5A5, gd, lat, dat);
        check("l1_wr_lat", lat, 32'd1);
        req(1, 1'b1, 1'b0, 16'h0002, 16'h0000, gd, lat, dat);
        check("l1_rd_lat", lat, 32'd1);
        check("l1_wrap_data", {16'b0, dat}, 32'h0000A5A5);

        // 6. odd address
        if (ALIGN) begin
            req(0, 1'b1, 1'b0, 16'h0011, 16'h0000, gd, lat, dat);
            count_pulses(0, 8, nd, ne);
            check("align_err", ne, 32'd1);
            check("align_no_done", nd, 32'd0);
        end else begin
            req(0, 1'b1, 1'b0, 16'h0011, 16'h0000, gd, lat, dat);
            check("odd_done", {31'b0, gd}, 32'd1);
            check("odd_alias", {16'b0, dat}, 32'h0000BEEF);
        end

        // randomized traffic, checked cycle by cycle by the model
        for (int it = 0; it < 80; it++) begin
            k  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 9));
            a  = 16'($urandom);
            a[AW:1] = 8'($urandom_range(0, 15));
            if (op == 0)
                req(k, 1'b1, 1'b1, a, 16'($urandom), gd, lat, dat);
            else if (op < 5)
                req(k, 1'b1, 1'b0, a, 16'($urandom), gd, lat, dat);
            else
                req(k, 1'b0, 1'b1, a, 16'($urandom), gd, lat, dat);
            if (gd) check("rand_lat", lat, lat_of(k));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
